// File: rtl/xunit_msg_sched.sv
// SHA-2 message-schedule unit: loads W[0..15] from in0, expands W[16..N-1] at one
// word per cycle and streams every W[t] on out0. Mode 0 = SHA-256, mode 1 = SHA-512.
module xunit_msg_sched #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DELAY_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  input  logic [DELAY_W-1:0] delay0,
  input  logic               mode0,
  input  logic [7:0]         rounds0
);

  typedef enum logic [1:0] {StIdle, StDelay, StLoad, StExpand} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  w_q [16];
  logic [DATA_W-1:0]  w_d [16];
  logic [DATA_W-1:0]  out0_q, out0_d;
  logic [DELAY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         n_q, n_d;
  logic               mode_q, mode_d;

  logic [7:0]         n_cfg;
  logic [DATA_W-1:0]  in_m;
  logic [DATA_W-1:0]  val;
  logic [63:0]        w14_x, w9_x, w1_x, w0_x;
  logic [31:0]        v32;
  logic [63:0]        v64, val64;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Effective round count: 0 selects the mode default, anything below 16 is raised to 16.
  always_comb begin
    logic m_eff;
    m_eff = (DATA_W > 32) ? mode0 : 1'b0;
    if (rounds0 == 8'd0) begin
      n_cfg = m_eff ? 8'd80 : 8'd64;
    end else if (rounds0 < 8'd16) begin
      n_cfg = 8'd16;
    end else begin
      n_cfg = rounds0;
    end
  end

  // New schedule word; computed in 64 bits so the 32-bit datapath build shares the code.
  always_comb begin
    w14_x = 64'(w_q[14]);
    w9_x  = 64'(w_q[9]);
    w1_x  = 64'(w_q[1]);
    w0_x  = 64'(w_q[0]);
    v32   = (rotr32(w14_x[31:0], 17) ^ rotr32(w14_x[31:0], 19) ^ (w14_x[31:0] >> 10))
          + w9_x[31:0]
          + (rotr32(w1_x[31:0], 7) ^ rotr32(w1_x[31:0], 18) ^ (w1_x[31:0] >> 3))
          + w0_x[31:0];
    v64   = (rotr64(w14_x, 19) ^ rotr64(w14_x, 61) ^ (w14_x >> 6))
          + w9_x
          + (rotr64(w1_x, 1) ^ rotr64(w1_x, 8) ^ (w1_x >> 7))
          + w0_x;
    val64 = mode_q ? v64 : {32'd0, v32};
    val   = DATA_W'(val64);
    // In mode 0 the upper half of a loaded word never enters the window.
    in_m  = mode_q ? in0 : (in0 & DATA_W'(64'hFFFF_FFFF));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; run overrides every state.
  always_comb begin
    state_d = state_q;
    if (run) begin
      state_d = (delay0 != '0) ? StDelay : StLoad;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StDelay:  if (dly_cnt_q == DELAY_W'(1)) state_d = StLoad;
        StLoad:   if (cnt_q == 8'd15) state_d = (n_q == 8'd16) ? StIdle : StExpand;
        StExpand: if (cnt_q == n_q - 8'd1) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state.
  always_comb begin
    done = (state_q == StIdle);
    out0 = out0_q;
  end

  // Datapath next-state: window shift, word counter, delay counter, config latch.
  always_comb begin
    for (int i = 0; i < 16; i++) w_d[i] = w_q[i];
    out0_d    = out0_q;
    dly_cnt_d = dly_cnt_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    mode_d    = mode_q;
    if (run) begin
      for (int i = 0; i < 16; i++) w_d[i] = '0;
      dly_cnt_d = delay0;
      cnt_d     = 8'd0;
      n_d       = n_cfg;
      mode_d    = (DATA_W > 32) ? mode0 : 1'b0;
    end else begin
      unique case (state_q)
        StDelay: dly_cnt_d = dly_cnt_q - DELAY_W'(1);
        StLoad: begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = in_m;
          out0_d  = in_m;
          cnt_d   = cnt_q + 8'd1;
        end
        StExpand: begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = val;
          out0_d  = val;
          cnt_d   = cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      out0_q    <= '0;
      dly_cnt_q <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      mode_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
      out0_q    <= out0_d;
      dly_cnt_q <= dly_cnt_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      mode_q    <= mode_d;
    end
  end

endmodule
